button_bounce_gen: RTL and testbench

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

---
 rtl/button_bounce_gen.sv | 164 ++++++++++++++++
 tb/tb_button_bounce_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_bounce_gen.sv
// button_bounce_gen: emulates a mechanical push button with contact bounce.
// Drives a registered bouncing level for exercising a debouncer.
module button_bounce_gen #(
  parameter int BOUNCE_CNT    = 3,
  parameter int GW            = 3,
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       button_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_count
);

  localparam int EW =
    (BOUNCE_CNT > 0) ? $clog2(2 * BOUNCE_CNT + 1) : 1;

  localparam logic [EW-1:0] LAST_E =
    EW'((BOUNCE_CNT > 0) ? 2 * BOUNCE_CNT - 1 : 0);

  localparam logic [15:0] HOLD_LAST =
    16'(HOLD_CYCLES - 1);

  localparam logic [15:0] SETTLE_LAST =
    16'(SETTLE_CYCLES - 1);

  localparam bit HAS_BOUNCE = (BOUNCE_CNT > 0);

  typedef enum logic [2:0] {
    IDLE,
    P_BOUNCE,
    HOLD,
    R_BOUNCE,
    SETTLE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      lfsr_q;
  logic [GW-1:0]   wcnt_q;
  logic [GW-1:0]   wcnt_d;
  logic [EW-1:0]   ecnt_q;
  logic [EW-1:0]   ecnt_d;
  logic [15:0]     hcnt_q;
  logic [15:0]     hcnt_d;
  logic            btn_d;
  logic            done_d;
  logic [7:0]      cnt_d;
  logic            fb;

  assign fb   = lfsr_q[7] ^ lfsr_q[5]
              ^ lfsr_q[4] ^ lfsr_q[3];
  assign busy = (state_q != IDLE);

  // Free-running x^8+x^6+x^5+x^4+1 source for glitch widths.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

  // State and output registers; reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      button_out  <= 1'b0;
      done        <= 1'b0;
      press_count <= 8'd0;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      hcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      button_out  <= btn_d;
      done        <= done_d;
      press_count <= cnt_d;
      wcnt_q      <= wcnt_d;
      ecnt_q      <= ecnt_d;
      hcnt_q      <= hcnt_d;
    end
  end

  // Next state: each bounce phase loads a fresh width w-1
  // from the LFSR on the edge that enters it.
  always_comb begin
    state_d = state_q;
    btn_d   = button_out;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    cnt_d   = press_count;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          btn_d   = 1'b1;
          ecnt_d  = '0;
          hcnt_d  = '0;
          wcnt_d  = lfsr_q[GW-1:0];
          state_d = HAS_BOUNCE ? P_BOUNCE : HOLD;
        end
      end
      P_BOUNCE: begin
        if (wcnt_q == '0) begin
          btn_d = ~button_out;
          if (ecnt_q == LAST_E) begin
            hcnt_d  = '0;
            state_d = HOLD;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
            wcnt_d = lfsr_q[GW-1:0];
          end
        end else begin
          wcnt_d = wcnt_q - GW'(1);
        end
      end
      HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          btn_d   = 1'b0;
          ecnt_d  = '0;
          hcnt_d  = '0;
          wcnt_d  = lfsr_q[GW-1:0];
          state_d = HAS_BOUNCE ? R_BOUNCE : SETTLE;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      R_BOUNCE: begin
        if (wcnt_q == '0) begin
          btn_d = ~button_out;
          if (ecnt_q == LAST_E) begin
            hcnt_d  = '0;
            state_d = SETTLE;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
            wcnt_d = lfsr_q[GW-1:0];
          end
        end else begin
          wcnt_d = wcnt_q - GW'(1);
        end
      end
      SETTLE: begin
        if (hcnt_q == SETTLE_LAST) begin
          hcnt_d  = '0;
          done_d  = 1'b1;
          cnt_d   = press_count + 8'd1;
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      default: begin
        btn_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen: random-stimulus bench for button_bounce_gen.
// Expected waveform built from level/width segments per press.
module tb_button_bounce_gen;

  localparam int BC = 3;
  localparam int GW = 3;
  localparam int HC = 16;
  localparam int SC = 16;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       start  = 1'b0;
  logic       start2 = 1'b0;
  logic       button_out;
  logic       busy;
  logic       done;
  logic [7:0] press_count;
  logic       b2_out;
  logic       b2_busy;
  logic       b2_done;
  logic [7:0] b2_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] exp_count = 8'd0;
  bit         exp_q[$];

  always #5 clk = ~clk;

  button_bounce_gen #(
    .BOUNCE_CNT(BC), .GW(GW),
    .HOLD_CYCLES(HC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .button_out(button_out), .busy(busy),
    .done(done), .press_count(press_count)
  );

  button_bounce_gen #(
    .BOUNCE_CNT(0), .GW(3),
    .HOLD_CYCLES(4), .SETTLE_CYCLES(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .button_out(b2_out), .busy(b2_busy),
    .done(b2_done), .press_count(b2_count)
  );

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Pseudo-random sequence as defined: seeded by reset, steps every edge.
  always @(posedge clk)
    m_lfsr <= !rst ? 8'hA5 : lfsr_step(m_lfsr);

  // Level per busy cycle: press glitches, hold, release glitches, settle.
  function automatic void build_trace(
    input logic [7:0] l0, output int pb);
    logic [7:0] l;
    bit lvl;
    int w;
    l = l0;
    lvl = 1'b1;
    pb = 0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 2 * BC; k++) begin
        w = (int'(l) % (1 << GW)) + 1;
        for (int i = 0; i < w; i++) begin
          exp_q.push_back(lvl);
          l = lfsr_step(l);
        end
        lvl = !lvl;
      end
      if (p == 0) pb = exp_q.size();
      for (int i = 0; i < (p == 0 ? HC : SC); i++) begin
        exp_q.push_back(lvl);
        l = lfsr_step(l);
      end
      lvl = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_count = 8'd0;
  endtask

  // mode 0: start low while busy, 1: random, 2: held high.
  task automatic run_seq(input int mode,
                         output int rises,
                         output int dones);
    int pb;
    bit prev;
    start = 1'b1;
    build_trace(m_lfsr, pb);
    rises = 0;
    dones = 0;
    prev = 1'b0;
    @(posedge clk);
    foreach (exp_q[c]) begin
      @(negedge clk);
      start = (mode == 2) ? 1'b1 :
              (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      checks++;
      if (button_out !== exp_q[c] || busy !== 1'b1
          || done !== 1'b0) begin
        errors++;
        $display("FAIL seq c=%0d btn/busy/done=%b%b%b req %b10",
                 c, button_out, busy, done, exp_q[c]);
      end
      if (button_out === 1'b1 && !prev) rises++;
      prev = button_out;
      if (done === 1'b1) dones++;
    end
    @(negedge clk);
    start = 1'b0;
    exp_count = exp_count + 8'd1;
    if (done === 1'b1) dones++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || button_out !== 1'b0
        || press_count !== exp_count) begin
      errors++;
      $display("FAIL seq_end done/busy/btn=%b%b%b cnt=%0d req 100 %0d",
               done, busy, button_out, press_count, exp_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (button_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0
        || press_count !== 8'd0) begin
      errors++;
      $display("FAIL reset btn/busy/done=%b%b%b cnt=%0d req 000 0",
               button_out, busy, done, press_count);
    end
    checks++;
    if (b2_out !== 1'b0 || b2_busy !== 1'b0 || b2_done !== 1'b0
        || b2_count !== 8'd0) begin
      errors++;
      $display("FAIL reset2 btn/busy/done=%b%b%b cnt=%0d req 000 0",
               b2_out, b2_busy, b2_done, b2_count);
    end
  endtask

  task automatic test_no_bounce();
    bit eb, ey, ed;
    start2 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      eb = (c < 4);
      ey = (c < 7);
      ed = (c == 7);
      checks++;
      if (b2_out !== eb || b2_busy !== ey || b2_done !== ed) begin
        errors++;
        $display("FAIL no_bounce c=%0d btn/busy/done=%b%b%b req %b%b%b",
                 c, b2_out, b2_busy, b2_done, eb, ey, ed);
      end
    end
    checks++;
    if (b2_count !== 8'd1) begin
      errors++;
      $display("FAIL no_bounce_count got %0d req 1", b2_count);
    end
  endtask

  task automatic test_single_press();
    int r, d;
    run_seq(0, r, d);
    checks++;
    if (r != 2 * BC + 1 || d != 1) begin
      errors++;
      $display("FAIL single rises=%0d dones=%0d req %0d 1",
               r, d, 2 * BC + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || button_out !== 1'b0) begin
      errors++;
      $display("FAIL single_after done/busy/btn=%b%b%b req 000",
               done, busy, button_out);
    end
  endtask

  task automatic test_busy_start();
    int r, d;
    for (int n = 0; n < 3; n++) begin
      run_seq(1, r, d);
      checks++;
      if (d != 1) begin
        errors++;
        $display("FAIL busy_start dones=%0d req 1", d);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int r, d, tot, cyc;
    logic [7:0] c0;
    c0 = press_count;
    tot = 0;
    cyc = 0;
    while (cyc < 100) begin
      run_seq(2, r, d);
      tot += d;
      cyc += exp_q.size() + 1;
    end
    checks++;
    if (press_count !== 8'(c0 + tot)) begin
      errors++;
      $display("FAIL b2b cnt=%0d req %0d", press_count, 8'(c0 + tot));
    end
  endtask

  task automatic test_wrap();
    int r, d, tot;
    do_reset();
    tot = 0;
    for (int n = 0; n < 256; n++) begin
      run_seq(n % 2, r, d);
      tot += d;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    checks++;
    if (press_count !== 8'd0 || tot % 256 != 0) begin
      errors++;
      $display("FAIL wrap cnt=%0d dones=%0d req 0 256",
               press_count, tot);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pb, r, d;
    do_reset();
    start = 1'b1;
    build_trace(m_lfsr, pb);
    @(posedge clk);
    for (int c = 0; c < pb + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (button_out !== exp_q[c] || busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_abort c=%0d btn=%b busy=%b req %b 1",
                 c, button_out, busy, exp_q[c]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (button_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0
        || press_count !== 8'd0) begin
      errors++;
      $display("FAIL abort btn/busy/done=%b%b%b cnt=%0d req 000 0",
               button_out, busy, done, press_count);
    end
    rst = 1'b1;
    exp_count = 8'd0;
    run_seq(0, r, d);
    checks++;
    if (r != 2 * BC + 1 || d != 1) begin
      errors++;
      $display("FAIL post_abort rises=%0d dones=%0d req %0d 1",
               r, d, 2 * BC + 1);
    end
  endtask

  initial begin
    test_reset();
    test_no_bounce();
    test_single_press();
    test_busy_start();
    test_back_to_back();
    test_wrap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
